ro_buffer: RTL

RO_BUFFER -- requirements
Module: ro_buffer

---
 rtl/ro_buffer_pkg.sv | 30 +++
 rtl/ro_buffer_lookup.sv | 50 +++++
 rtl/ro_buffer.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/ro_buffer_pkg.sv
// Shared types for the reorder buffer and the register file it commits into.
// Slot 0 is reserved as "no entry", so IDs run 1..RO_BUFFER_SIZE-1.
package ro_buffer_pkg;

    localparam int ROB_SIZE_DEFAULT = 16;
    localparam int REG_W            = 32;
    localparam int REG_ID_W         = 5;
    localparam int ROB_ID_W         = 4;
    localparam int PC_W             = 32;

    typedef logic [REG_W-1:0]    REG_TYPE;
    typedef logic [REG_ID_W-1:0] REG_ID_TYPE;
    typedef logic [ROB_ID_W-1:0] RO_BUFFER_ID_TYPE;

    typedef struct packed {
        REG_ID_TYPE      rd;
        logic            is_branch;
        logic            pred_taken;
        logic            taken;
        REG_TYPE         value;
        logic [PC_W-1:0] pc;
    } rob_entry_t;

    // Circular increment that skips the reserved ID 0.
    function automatic RO_BUFFER_ID_TYPE next_id(input RO_BUFFER_ID_TYPE id,
                                                 input RO_BUFFER_ID_TYPE last_id);
        return (id == last_id) ? RO_BUFFER_ID_TYPE'(1) : id + RO_BUFFER_ID_TYPE'(1);
    endfunction

endpackage

// File: rtl/ro_buffer_lookup.sv
// Dual combinational operand read; a same-cycle CDB writeback to the named
// entry is forwarded so the issuer does not wait a cycle for it.
module ro_buffer_lookup
    import ro_buffer_pkg::*;
#(
    parameter int RO_BUFFER_SIZE = ROB_SIZE_DEFAULT
) (
    input  logic [RO_BUFFER_SIZE-1:0] busy_i,
    input  logic [RO_BUFFER_SIZE-1:0] ready_i,
    input  REG_TYPE                   value_i [RO_BUFFER_SIZE],
    input  logic                      cdb_valid_i,
    input  RO_BUFFER_ID_TYPE          cdb_dest_i,
    input  REG_TYPE                   cdb_value_i,
    input  RO_BUFFER_ID_TYPE          qj_i,
    input  RO_BUFFER_ID_TYPE          qk_i,
    output logic                      ready_j_o,
    output REG_TYPE                   value_j_o,
    output logic                      ready_k_o,
    output REG_TYPE                   value_k_o
);

    always_comb begin
        ready_j_o = 1'b0;
        value_j_o = '0;
        if (qj_i != '0 && busy_i[qj_i]) begin
            if (cdb_valid_i && cdb_dest_i == qj_i) begin
                ready_j_o = 1'b1;
                value_j_o = cdb_value_i;
            end else if (ready_i[qj_i]) begin
                ready_j_o = 1'b1;
                value_j_o = value_i[qj_i];
            end
        end
    end

    always_comb begin
        ready_k_o = 1'b0;
        value_k_o = '0;
        if (qk_i != '0 && busy_i[qk_i]) begin
            if (cdb_valid_i && cdb_dest_i == qk_i) begin
                ready_k_o = 1'b1;
                value_k_o = cdb_value_i;
            end else if (ready_i[qk_i]) begin
                ready_k_o = 1'b1;
                value_k_o = value_i[qk_i];
            end
        end
    end

endmodule

// File: rtl/ro_buffer.sv
// Reorder buffer: in-order allocate, out-of-order CDB writeback, in-order
// single commit per cycle, with a full flush on a mispredicted branch.
module ro_buffer
    import ro_buffer_pkg::*;
#(
    parameter int RO_BUFFER_SIZE = ROB_SIZE_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,

    input  logic             valid_from_issuer,
    input  REG_ID_TYPE       rd_from_issuer,
    input  logic             is_branch_from_issuer,
    input  logic             pred_taken_from_issuer,
    output RO_BUFFER_ID_TYPE dest_to_issuer,
    output logic             full_to_issuer,

    input  logic             valid_from_cdb,
    input  RO_BUFFER_ID_TYPE dest_from_cdb,
    input  REG_TYPE          value_from_cdb,
    input  logic             taken_from_cdb,
    input  logic [PC_W-1:0]  pc_from_cdb,

    input  RO_BUFFER_ID_TYPE qj_from_issuer,
    input  RO_BUFFER_ID_TYPE qk_from_issuer,
    output logic             ready_j,
    output REG_TYPE          value_j,
    output logic             ready_k,
    output REG_TYPE          value_k,

    output RO_BUFFER_ID_TYPE dest_to_reg_file,
    output REG_ID_TYPE       rd_to_reg_file,
    output REG_TYPE          value_to_reg_file,

    output logic             reset_to_rob_bus,
    output logic [PC_W-1:0]  pc_to_fetcher
);

    localparam RO_BUFFER_ID_TYPE LAST_ID = RO_BUFFER_ID_TYPE'(RO_BUFFER_SIZE - 1);

    logic [RO_BUFFER_SIZE-1:0] busy_q, busy_d;
    logic [RO_BUFFER_SIZE-1:0] ready_q, ready_d;
    rob_entry_t                entry_q [RO_BUFFER_SIZE];
    rob_entry_t                entry_d [RO_BUFFER_SIZE];
    REG_TYPE                   entry_value [RO_BUFFER_SIZE];

    RO_BUFFER_ID_TYPE head_q, head_d;
    RO_BUFFER_ID_TYPE tail_q, tail_d;
    RO_BUFFER_ID_TYPE count_q, count_d;

    RO_BUFFER_ID_TYPE commit_dest_q, commit_dest_d;
    REG_ID_TYPE       commit_rd_q, commit_rd_d;
    REG_TYPE          commit_value_q, commit_value_d;
    logic             flush_q, flush_d;
    logic [PC_W-1:0]  flush_pc_q, flush_pc_d;

    logic       full;
    logic       alloc;
    logic       cdb_wr;
    logic       commit;
    logic       mispredict;
    rob_entry_t head_entry;

    // Full comes from the registered count, so a same-cycle commit never frees a slot early.
    assign full       = (count_q == LAST_ID);
    assign alloc      = valid_from_issuer && !full;
    assign cdb_wr     = valid_from_cdb && (dest_from_cdb != '0) && busy_q[dest_from_cdb];
    assign head_entry = entry_q[head_q];
    assign commit     = busy_q[head_q] && ready_q[head_q];
    assign mispredict = commit && head_entry.is_branch &&
                        (head_entry.taken != head_entry.pred_taken);

    always_comb begin
        busy_d         = busy_q;
        ready_d        = ready_q;
        entry_d        = entry_q;
        head_d         = head_q;
        tail_d         = tail_q;
        count_d        = count_q;
        commit_dest_d  = '0;
        commit_rd_d    = '0;
        commit_value_d = '0;
        flush_d        = 1'b0;
        flush_pc_d     = '0;

        if (commit) begin
            commit_dest_d  = head_q;
            commit_rd_d    = head_entry.rd;
            commit_value_d = head_entry.value;
        end

        if (mispredict) begin
            flush_d    = 1'b1;
            flush_pc_d = head_entry.pc;
            busy_d     = '0;
            ready_d    = '0;
            head_d     = RO_BUFFER_ID_TYPE'(1);
            tail_d     = RO_BUFFER_ID_TYPE'(1);
            count_d    = '0;
        end else begin
            if (cdb_wr) begin
                ready_d[dest_from_cdb]       = 1'b1;
                entry_d[dest_from_cdb].value = value_from_cdb;
                entry_d[dest_from_cdb].taken = taken_from_cdb;
                entry_d[dest_from_cdb].pc    = pc_from_cdb;
            end
            if (commit) begin
                busy_d[head_q]  = 1'b0;
                ready_d[head_q] = 1'b0;
                head_d          = next_id(head_q, LAST_ID);
            end
            // head == tail only when empty or full, so commit and alloc never share a slot.
            if (alloc) begin
                busy_d[tail_q]             = 1'b1;
                ready_d[tail_q]            = 1'b0;
                entry_d[tail_q].rd         = rd_from_issuer;
                entry_d[tail_q].is_branch  = is_branch_from_issuer;
                entry_d[tail_q].pred_taken = pred_taken_from_issuer;
                tail_d                     = next_id(tail_q, LAST_ID);
            end
            case ({alloc, commit})
                2'b10:   count_d = count_q + RO_BUFFER_ID_TYPE'(1);
                2'b01:   count_d = count_q - RO_BUFFER_ID_TYPE'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_q         <= '0;
            ready_q        <= '0;
            head_q         <= RO_BUFFER_ID_TYPE'(1);
            tail_q         <= RO_BUFFER_ID_TYPE'(1);
            count_q        <= '0;
            commit_dest_q  <= '0;
            commit_rd_q    <= '0;
            commit_value_q <= '0;
            flush_q        <= 1'b0;
            flush_pc_q     <= '0;
        end else if (rdy) begin
            busy_q         <= busy_d;
            ready_q        <= ready_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            commit_dest_q  <= commit_dest_d;
            commit_rd_q    <= commit_rd_d;
            commit_value_q <= commit_value_d;
            flush_q        <= flush_d;
            flush_pc_q     <= flush_pc_d;
        end
    end

    // Payload is only ever read behind a busy/ready bit, so it needs no reset.
    always_ff @(posedge clk) begin
        if (rdy) begin
            entry_q <= entry_d;
        end
    end

    always_comb begin
        for (int i = 0; i < RO_BUFFER_SIZE; i++) begin
            entry_value[i] = entry_q[i].value;
        end
    end

    ro_buffer_lookup #(
        .RO_BUFFER_SIZE (RO_BUFFER_SIZE)
    ) u_lookup (
        .busy_i      (busy_q),
        .ready_i     (ready_q),
        .value_i     (entry_value),
        .cdb_valid_i (valid_from_cdb && rdy),
        .cdb_dest_i  (dest_from_cdb),
        .cdb_value_i (value_from_cdb),
        .qj_i        (qj_from_issuer),
        .qk_i        (qk_from_issuer),
        .ready_j_o   (ready_j),
        .value_j_o   (value_j),
        .ready_k_o   (ready_k),
        .value_k_o   (value_k)
    );

    assign dest_to_issuer    = full ? '0 : tail_q;
    assign full_to_issuer    = full;
    assign dest_to_reg_file  = commit_dest_q;
    assign rd_to_reg_file    = commit_rd_q;
    assign value_to_reg_file = commit_value_q;
    assign reset_to_rob_bus  = flush_q;
    assign pc_to_fetcher     = flush_pc_q;

endmodule
